// File: rtl/scr1_tcm_arb_pkg.sv
// -----------------------------------------------------------------------------
// scr1_tcm_arb_pkg
// Shared types and helpers for the two-requester TCM arbiter:
//   - command, access width and response encodings
//   - byte-mask, legality, store lane replication and load extraction helpers
// -----------------------------------------------------------------------------
package scr1_tcm_arb_pkg;

    typedef enum logic {
        TCM_CMD_RD = 1'b0,
        TCM_CMD_WR = 1'b1
    } tcm_cmd_e;

    typedef enum logic [1:0] {
        TCM_WIDTH_BYTE = 2'd0,
        TCM_WIDTH_HALF = 2'd1,
        TCM_WIDTH_WORD = 2'd2,
        TCM_WIDTH_RSVD = 2'd3
    } tcm_width_e;

    typedef enum logic [1:0] {
        TCM_RESP_IDLE = 2'd0,
        TCM_RESP_RDY  = 2'd1,
        TCM_RESP_ERR  = 2'd2
    } tcm_resp_e;

    // Unshifted byte-enable pattern for an access size.
    function automatic logic [3:0] tcm_byte_mask(input logic [1:0] width);
        logic [3:0] mask;
        case (width)
            TCM_WIDTH_BYTE: mask = 4'b0001;
            TCM_WIDTH_HALF: mask = 4'b0011;
            TCM_WIDTH_WORD: mask = 4'b1111;
            default:        mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // Natural alignment check; the reserved size is never legal.
    function automatic logic tcm_access_legal(input logic [1:0] width, input logic [1:0] off);
        logic ok;
        case (width)
            TCM_WIDTH_BYTE: ok = 1'b1;
            TCM_WIDTH_HALF: ok = (off[0] == 1'b0);
            TCM_WIDTH_WORD: ok = (off == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Copy LSB-aligned store data into every lane so the byte enables pick the right one.
    function automatic logic [31:0] tcm_lane_replicate(input logic [1:0] width, input logic [31:0] wdata);
        logic [31:0] data;
        case (width)
            TCM_WIDTH_BYTE: data = {4{wdata[7:0]}};
            TCM_WIDTH_HALF: data = {2{wdata[15:0]}};
            default:        data = wdata;
        endcase
        return data;
    endfunction

    // Bring the addressed bytes down to bit 0 and zero-extend by size.
    function automatic logic [31:0] tcm_load_extract(input logic [31:0] qb, input logic [1:0] off,
                                                     input logic [1:0] width);
        logic [31:0] sh;
        logic [31:0] data;
        sh = qb >> {off, 3'b000};
        case (width)
            TCM_WIDTH_BYTE: data = {24'h0, sh[7:0]};
            TCM_WIDTH_HALF: data = {16'h0, sh[15:0]};
            default:        data = sh;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/scr1_tcm_arb_if.sv
// -----------------------------------------------------------------------------
// scr1_tcm_arb_if
// Bundles the two requester ports and the memory port B of the TCM arbiter.
//   Requester side : req, req_cmd, req_width, req_addr, req_wdata (to arbiter)
//                    req_ack, req_rdata, req_resp (from arbiter)
//   Memory side    : renb, wenb, webb, addrb, datab (from arbiter), qb (to arbiter)
// Modports: slave  = arbiter view, master = requesters/memory view.
// -----------------------------------------------------------------------------
interface scr1_tcm_arb_if #(
    parameter int AW = 16
);
    logic [1:0]           req;
    logic [1:0]           req_ack;
    logic [1:0]           req_cmd;
    logic [1:0][1:0]      req_width;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0][31:0]     req_wdata;
    logic [1:0][31:0]     req_rdata;
    logic [1:0][1:0]      req_resp;

    logic                 renb;
    logic                 wenb;
    logic [3:0]           webb;
    logic [AW-1:0]        addrb;
    logic [31:0]          datab;
    logic [31:0]          qb;

    modport slave (
        input  req, req_cmd, req_width, req_addr, req_wdata, qb,
        output req_ack, req_rdata, req_resp, renb, wenb, webb, addrb, datab
    );

    modport master (
        output req, req_cmd, req_width, req_addr, req_wdata, qb,
        input  req_ack, req_rdata, req_resp, renb, wenb, webb, addrb, datab
    );
endinterface

// File: rtl/scr1_tcm_arb_rr.sv
// -----------------------------------------------------------------------------
// scr1_tcm_arb_rr
// Two-way round-robin picker.
//   i_req  [1:0] : active requests
//   i_last       : requester served by the most recent accepted request
//   o_gnt  [1:0] : one-hot grant (zero when nothing requests)
// -----------------------------------------------------------------------------
module scr1_tcm_arb_rr
    import scr1_tcm_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);
    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // Contention: hand the slot to whoever was not served last.
            2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/scr1_tcm_arb.sv
// -----------------------------------------------------------------------------
// scr1_tcm_arb
// Arbitrates the core LSU (requester 0) and DMA/debug (requester 1) onto port B
// of the tightly-coupled memory. One request is accepted per cycle; its
// response (RDY/ERR plus read data) is returned exactly one cycle later.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester handshake/data and memory port B (slave modport)
// -----------------------------------------------------------------------------
module scr1_tcm_arb
    import scr1_tcm_arb_pkg::*;
#(
    parameter int          SCR1_WIDTH = 32,
    parameter logic [31:0] SCR1_SIZE  = 32'h0001_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    scr1_tcm_arb_if.slave bus
);
    localparam int AW = $clog2(SCR1_SIZE);

    logic                  r_last;
    logic                  r_vld_p1;
    logic                  r_id_p1;
    logic                  r_err_p1;
    logic                  r_cmd_p1;
    logic [1:0]            r_off_p1;
    logic [1:0]            r_width_p1;

    logic [1:0]            w_req_p0;
    logic [1:0]            w_gnt_p0;
    logic                  w_acc_p0;
    logic                  w_id_p0;
    logic                  w_cmd_p0;
    logic                  w_err_p0;
    logic                  w_rd_p0;
    logic                  w_wr_p0;
    logic [1:0]            w_width_p0;
    logic [1:0]            w_off_p0;
    logic [AW-1:0]         w_addr_p0;
    logic [31:0]           w_wdata_p0;
    logic [SCR1_WIDTH-1:0] w_datab_p0;

    // ---- p0: arbitration, decode and memory strobes (acceptance cycle) ----
    // Nothing is accepted while reset is held, so no ack or strobe leaks out.
    assign w_req_p0 = bus.req & {2{rst_n}};

    scr1_tcm_arb_rr u_rr (
        .i_req  (w_req_p0),
        .i_last (r_last),
        .o_gnt  (w_gnt_p0)
    );

    assign bus.req_ack = w_gnt_p0;

    always_comb begin
        w_acc_p0   = |w_gnt_p0;
        w_id_p0    = w_gnt_p0[1];
        w_cmd_p0   = bus.req_cmd[w_id_p0];
        w_width_p0 = bus.req_width[w_id_p0];
        w_addr_p0  = bus.req_addr[w_id_p0];
        w_wdata_p0 = bus.req_wdata[w_id_p0];
        w_off_p0   = w_addr_p0[1:0];
        w_err_p0   = !tcm_access_legal(w_width_p0, w_off_p0);
        w_rd_p0    = w_acc_p0 && !w_err_p0 && (w_cmd_p0 == TCM_CMD_RD);
        w_wr_p0    = w_acc_p0 && !w_err_p0 && (w_cmd_p0 == TCM_CMD_WR);
        w_datab_p0 = tcm_lane_replicate(w_width_p0, w_wdata_p0);
    end

    assign bus.renb  = w_rd_p0;
    assign bus.wenb  = w_wr_p0;
    // Legal accesses never shift mask bits past lane 3, so the 4-bit truncation is safe.
    assign bus.webb  = w_wr_p0 ? (tcm_byte_mask(w_width_p0) << w_off_p0) : 4'b0000;
    assign bus.addrb = w_addr_p0;
    assign bus.datab = w_datab_p0;

    // ---- p1: pending response register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_vld_p1 <= 1'b0;
            r_id_p1  <= 1'b0;
            r_err_p1 <= 1'b0;
            r_cmd_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_acc_p0;
            if (w_acc_p0) begin
                r_last   <= w_id_p0;
                r_id_p1  <= w_id_p0;
                r_err_p1 <= w_err_p0;
                r_cmd_p1 <= w_cmd_p0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_p0) begin
            r_off_p1   <= w_off_p0;
            r_width_p1 <= w_width_p0;
        end
    end

    // ---- p1: response and load data back to the accepted requester ----
    // qb carries the word read at the end of the acceptance cycle.
    always_comb begin
        bus.req_resp  = '0;
        bus.req_rdata = '0;
        if (r_vld_p1) begin
            bus.req_resp[r_id_p1] = r_err_p1 ? TCM_RESP_ERR : TCM_RESP_RDY;
            if (!r_err_p1 && (r_cmd_p1 == TCM_CMD_RD)) begin
                bus.req_rdata[r_id_p1] = tcm_load_extract(bus.qb, r_off_p1, r_width_p1);
            end
        end
    end

endmodule

// File: tb/tb_scr1_tcm_arb.sv
module tb_scr1_tcm_arb;
    import scr1_tcm_arb_pkg::*;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst_n;

    scr1_tcm_arb_if #(.AW(AW)) bus ();

    scr1_tcm_arb #(
        .SCR1_WIDTH (32),
        .SCR1_SIZE  (32'h0001_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        id;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        tb_last;

    logic [31:0] ref_mem [0:16383];
    logic [31:0] mem     [0:16383];
    bit          mem_vld [0:16383];
    logic [31:0] mem_tmp;

    function automatic logic [31:0] mem_init_val(input logic [13:0] idx);
        return {2'b10, idx, ~idx, 2'b01};
    endfunction

    function automatic logic [31:0] mem_rd(input logic [13:0] idx);
        return mem_vld[idx] ? mem[idx] : mem_init_val(idx);
    endfunction

    // Port-B memory model: registered read, byte-enabled write.
    always @(posedge clk) begin
        if (bus.renb) bus.qb <= mem_rd(bus.addrb[15:2]);
        if (bus.wenb) begin
            mem_tmp = mem_rd(bus.addrb[15:2]);
            for (int b = 0; b < 4; b++)
                if (bus.webb[b]) mem_tmp[8*b +: 8] = bus.datab[8*b +: 8];
            mem[bus.addrb[15:2]]     <= mem_tmp;
            mem_vld[bus.addrb[15:2]] <= 1'b1;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: response expected one cycle after its acceptance.
    exp_t             m_e;
    logic [1:0][1:0]  m_er;
    logic [1:0][31:0] m_ed;
    always @(negedge clk) begin
        m_er = '0;
        m_ed = '0;
        if (q.size() > 0 && q[0].cyc == cyc - 1) begin
            m_e = q.pop_front();
            m_er[m_e.id] = m_e.resp;
            m_ed[m_e.id] = m_e.rdata;
        end
        checks++;
        if (bus.req_resp !== m_er) begin
            errors++;
            $display("FAIL sb_resp cyc=%0d: got %h expected %h", cyc, bus.req_resp, m_er);
        end
        checks++;
        if (bus.req_rdata !== m_ed) begin
            errors++;
            $display("FAIL sb_rdata cyc=%0d: got %h expected %h", cyc, bus.req_rdata, m_ed);
        end
    end

    // Drive one cycle of stimulus and push the model's expected response.
    task automatic apply(input logic rst_v, input logic [1:0] rq, input logic [1:0] cmd,
                         input logic [1:0][1:0] wd, input logic [1:0][15:0] ad,
                         input logic [1:0][31:0] wdat,
                         output logic [1:0] g, output logic erd, output logic ewr);
        exp_t        e;
        logic        id;
        logic [1:0]  w;
        logic [1:0]  off;
        logic        legal;
        logic [31:0] sh;
        @(posedge clk);
        #1;
        rst_n         = rst_v;
        bus.req       = rq;
        bus.req_cmd   = cmd;
        bus.req_width = wd;
        bus.req_addr  = ad;
        bus.req_wdata = wdat;
        g   = 2'b00;
        erd = 1'b0;
        ewr = 1'b0;
        if (!rst_v) begin
            tb_last = 1'b1;
            q.delete();
        end else if (rq == 2'b01) begin
            g = 2'b01;
        end else if (rq == 2'b10) begin
            g = 2'b10;
        end else if (rq == 2'b11) begin
            g = tb_last ? 2'b01 : 2'b10;
        end
        if (g != 2'b00) begin
            id    = g[1];
            w     = wd[id];
            off   = ad[id][1:0];
            legal = (w == 2'd0) || (w == 2'd1 && off[0] == 1'b0) || (w == 2'd2 && off == 2'd0);
            e.cyc   = cyc;
            e.id    = id;
            e.rdata = 32'h0;
            if (!legal) begin
                e.resp = 2'd2;
            end else begin
                e.resp = 2'd1;
                if (cmd[id]) begin
                    ewr = 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        logic en;
                        case (w)
                            2'd0:    en = (b == int'(off));
                            2'd1:    en = (b == int'(off)) || (b == int'(off) + 1);
                            default: en = 1'b1;
                        endcase
                        if (en)
                            ref_mem[ad[id][15:2]][8*b +: 8] = (w == 2'd0) ? wdat[id][7:0] :
                                (w == 2'd1) ? wdat[id][8*(b%2) +: 8] : wdat[id][8*b +: 8];
                    end
                end else begin
                    erd = 1'b1;
                    sh  = ref_mem[ad[id][15:2]] >> (8*off);
                    case (w)
                        2'd0:    e.rdata = {24'h0, sh[7:0]};
                        2'd1:    e.rdata = {16'h0, sh[15:0]};
                        default: e.rdata = sh;
                    endcase
                end
            end
            q.push_back(e);
            tb_last = id;
        end
    endtask

    task automatic req_one(input logic id, input logic cmd, input logic [1:0] w,
                           input logic [15:0] a, input logic [31:0] d);
        logic [1:0]       rq;
        logic [1:0]       c;
        logic [1:0][1:0]  wd;
        logic [1:0][15:0] ad;
        logic [1:0][31:0] wdat;
        logic [1:0]       g;
        logic             erd, ewr;
        rq = '0; c = '0; wd = '0; ad = '0; wdat = '0;
        rq[id] = 1'b1; c[id] = cmd; wd[id] = w; ad[id] = a; wdat[id] = d;
        apply(1'b1, rq, c, wd, ad, wdat, g, erd, ewr);
    endtask

    task automatic idle();
        logic [1:0] g;
        logic       erd, ewr;
        apply(1'b1, 2'b00, '0, '0, '0, '0, g, erd, ewr);
    endtask

    task automatic test_reset();
        logic [1:0] g;
        logic       erd, ewr;
        apply(1'b0, 2'b11, 2'b00, {2'd2, 2'd2}, {16'h0004, 16'h0000}, '0, g, erd, ewr);
        @(negedge clk);
        checks++; if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", bus.req_ack); end
        checks++; if (bus.renb !== 1'b0) begin errors++; $display("FAIL reset_renb: got %b expected 0", bus.renb); end
        checks++; if (bus.wenb !== 1'b0) begin errors++; $display("FAIL reset_wenb: got %b expected 0", bus.wenb); end
        checks++; if (bus.webb !== 4'b0000) begin errors++; $display("FAIL reset_webb: got %b expected 0000", bus.webb); end
        checks++; if (bus.req_resp !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %h expected 0", bus.req_resp); end
        checks++; if (bus.req_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", bus.req_rdata); end
        idle();
    endtask

    task automatic test_round_robin();
        logic [1:0]       g, exp_ack;
        logic             erd, ewr, pid;
        logic [1:0][15:0] ad;
        for (int i = 0; i < 6; i++) begin
            ad[0] = 16'h0200 + 16'(i*8);
            ad[1] = 16'h0100 + 16'(i*4);
            apply(1'b1, 2'b11, 2'b00, {2'd2, 2'd2}, ad, '0, g, erd, ewr);
            @(negedge clk);
            exp_ack = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (bus.req_ack !== exp_ack) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, bus.req_ack, exp_ack); end
            checks++; if (bus.renb !== 1'b1) begin errors++; $display("FAIL rr_renb[%0d]: got %b expected 1", i, bus.renb); end
            if (i > 0) begin
                pid = ((i - 1) % 2 == 1);
                checks++;
                if (bus.req_resp[pid] !== 2'd1 || bus.req_resp[!pid] !== 2'd0) begin
                    errors++; $display("FAIL rr_resp[%0d]: got %h expected RDY on requester %0d only", i, bus.req_resp, pid);
                end
            end
        end
        idle();
    endtask

    task automatic test_byte_wr_rd();
        req_one(1'b0, 1'b1, 2'd0, 16'h0003, 32'h0000_00A5);
        @(negedge clk);
        checks++; if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL bw_ack: got %b expected 01", bus.req_ack); end
        checks++; if (bus.wenb !== 1'b1) begin errors++; $display("FAIL bw_wenb: got %b expected 1", bus.wenb); end
        checks++; if (bus.webb !== 4'b1000) begin errors++; $display("FAIL bw_webb: got %b expected 1000", bus.webb); end
        checks++; if (bus.datab[31:24] !== 8'hA5) begin errors++; $display("FAIL bw_datab: got %h expected a5", bus.datab[31:24]); end
        req_one(1'b0, 1'b0, 2'd0, 16'h0003, 32'h0);
        @(negedge clk);
        checks++; if (bus.renb !== 1'b1 || bus.addrb !== 16'h0003) begin errors++; $display("FAIL br_strobe: got renb=%b addrb=%h expected 1/0003", bus.renb, bus.addrb); end
        idle();
        @(negedge clk);
        checks++; if (bus.req_rdata[0] !== 32'h0000_00A5) begin errors++; $display("FAIL br_rdata: got %h expected 000000a5", bus.req_rdata[0]); end
    endtask

    task automatic test_error();
        req_one(1'b1, 1'b0, 2'd2, 16'h0002, 32'h0);
        @(negedge clk);
        checks++; if (bus.req_ack !== 2'b10) begin errors++; $display("FAIL err_ack: got %b expected 10", bus.req_ack); end
        checks++; if (bus.renb !== 1'b0) begin errors++; $display("FAIL err_renb: got %b expected 0", bus.renb); end
        req_one(1'b1, 1'b1, 2'd3, 16'h0040, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (bus.req_resp[1] !== 2'd2 || bus.req_rdata[1] !== 32'h0) begin errors++; $display("FAIL err_resp: got resp=%0d rdata=%h expected 2/0", bus.req_resp[1], bus.req_rdata[1]); end
        checks++; if (bus.wenb !== 1'b0 || bus.webb !== 4'b0000) begin errors++; $display("FAIL err_rsvd_wr: got wenb=%b webb=%b expected 0/0000", bus.wenb, bus.webb); end
        req_one(1'b0, 1'b1, 2'd1, 16'h0041, 32'h0000_1234);
        @(negedge clk);
        checks++; if (bus.wenb !== 1'b0 || bus.webb !== 4'b0000) begin errors++; $display("FAIL err_mis_wr: got wenb=%b webb=%b expected 0/0000", bus.wenb, bus.webb); end
        idle();
        @(negedge clk);
        checks++; if (bus.req_resp[0] !== 2'd2) begin errors++; $display("FAIL err_mis_resp: got %0d expected 2", bus.req_resp[0]); end
    endtask

    task automatic test_half();
        logic [31:0] old;
        old = ref_mem[4];
        req_one(1'b0, 1'b1, 2'd1, 16'h0010, 32'h0000_BEEF);
        @(negedge clk);
        checks++; if (bus.webb !== 4'b0011) begin errors++; $display("FAIL hw_webb: got %b expected 0011", bus.webb); end
        checks++; if (bus.datab !== 32'hBEEF_BEEF) begin errors++; $display("FAIL hw_datab: got %h expected beefbeef", bus.datab); end
        req_one(1'b1, 1'b0, 2'd2, 16'h0010, 32'h0);
        @(negedge clk);
        checks++; if (bus.renb !== 1'b1) begin errors++; $display("FAIL hr_renb: got %b expected 1", bus.renb); end
        req_one(1'b1, 1'b1, 2'd1, 16'h0022, 32'h0000_C0DE);
        @(negedge clk);
        checks++; if (bus.req_rdata[1] !== {old[31:16], 16'hBEEF}) begin errors++; $display("FAIL hr_rdata: got %h expected %h", bus.req_rdata[1], {old[31:16], 16'hBEEF}); end
        checks++; if (bus.webb !== 4'b1100) begin errors++; $display("FAIL hw_hi_webb: got %b expected 1100", bus.webb); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [1:0]       rq, c, g;
        logic [1:0][1:0]  wd;
        logic [1:0][15:0] ad;
        logic [1:0][31:0] wdat;
        logic             erd, ewr;
        for (int i = 0; i < 150; i++) begin
            rq = 2'($urandom_range(0, 3));
            c  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                wd[k]   = 2'($urandom_range(0, 3));
                ad[k]   = 16'($urandom_range(0, 31));
                wdat[k] = $urandom;
            end
            apply(1'b1, rq, c, wd, ad, wdat, g, erd, ewr);
            @(negedge clk);
            checks++; if (bus.req_ack !== g) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", i, bus.req_ack, g); end
            checks++; if (bus.renb !== erd || bus.wenb !== ewr) begin errors++; $display("FAIL b2b_strobe[%0d]: got r%b w%b expected r%b w%b", i, bus.renb, bus.wenb, erd, ewr); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        logic       erd, ewr;
        req_one(1'b0, 1'b0, 2'd2, 16'h0020, 32'h0);
        apply(1'b0, 2'b11, 2'b00, {2'd2, 2'd2}, {16'h0024, 16'h0028}, '0, g, erd, ewr);
        @(negedge clk);
        checks++; if (bus.req_resp !== 4'b0000) begin errors++; $display("FAIL rm_resp: got %h expected 0", bus.req_resp); end
        checks++; if (bus.renb !== 1'b0 || bus.wenb !== 1'b0 || bus.webb !== 4'b0000) begin errors++; $display("FAIL rm_strobe: got r%b w%b be%b expected 0", bus.renb, bus.wenb, bus.webb); end
        checks++; if (bus.req_ack !== 2'b00) begin errors++; $display("FAIL rm_ack: got %b expected 00", bus.req_ack); end
        apply(1'b0, 2'b00, '0, '0, '0, '0, g, erd, ewr);
        @(negedge clk);
        checks++; if (bus.req_resp !== 4'b0000) begin errors++; $display("FAIL rm_resp_hold: got %h expected 0", bus.req_resp); end
        apply(1'b1, 2'b11, 2'b00, {2'd2, 2'd2}, {16'h0024, 16'h0028}, '0, g, erd, ewr);
        @(negedge clk);
        checks++; if (bus.req_ack !== 2'b01) begin errors++; $display("FAIL rm_first_gnt: got %b expected 01", bus.req_ack); end
        idle();
        idle();
    endtask

    initial begin
        rst_n         = 1'b0;
        tb_last       = 1'b1;
        bus.req       = '0;
        bus.req_cmd   = '0;
        bus.req_width = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 16384; i++) ref_mem[i] = mem_init_val(14'(i));

        test_reset();
        test_round_robin();
        test_byte_wr_rd();
        test_error();
        test_half();
        test_back_to_back();
        test_reset_mid();
        idle();
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_tcm_arb.md
SCR1_TCM_ARB -- requirements
Module: scr1_tcm_arb

Interface
REQ-001 SHALL have parameter SCR1_WIDTH, default 32, memory data width in bits; fixed at 32 for this block.
REQ-002 SHALL have parameter SCR1_SIZE, default 32'h00010000, memory size in bytes; AW = $clog2(SCR1_SIZE).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, [1:0], access request per requester (0 = core LSU, 1 = DMA/debug).
REQ-006 SHALL have port req_ack, output, [1:0], request accepted this cycle.
REQ-007 SHALL have port req_cmd, input, [1:0], per-requester command: 0 read, 1 write.
REQ-008 SHALL have port req_width, input, [1:0][1:0], size: 0 byte, 1 half, 2 word, 3 reserved.
REQ-009 SHALL have port req_addr, input, [1:0][AW-1:0], byte address.
REQ-010 SHALL have port req_wdata, input, [1:0][31:0], write data, LSB-aligned.
REQ-011 SHALL have port req_rdata, output, [1:0][31:0], read data, LSB-aligned.
REQ-012 SHALL have port req_resp, output, [1:0][1:0], response: 0 IDLE, 1 RDY, 2 ERR.
REQ-013 SHALL have memory-side outputs renb (1), wenb (1), webb (4), addrb (AW) and datab (32), plus input qb (32), matching the dual-port memory's port B.

Function
REQ-014 SHALL accept at most one request per cycle; req_ack[i] SHALL be combinational and asserted only while req[i]=1 and requester i holds the grant.
REQ-015 Arbitration SHALL be round-robin: if exactly one req is high, grant it; if both are high, grant the requester not served by the last accepted request; the last-served pointer SHALL update only on an accepted request.
REQ-016 A legal access is word aligned for width 2, half aligned for width 1, and any address for width 0. Width 3 or misalignment SHALL be an error.
REQ-017 Accepted legal read: renb=1 and addrb=req_addr in the acceptance cycle.
REQ-018 Accepted legal write: wenb=1 in the acceptance cycle, webb = size mask shifted by addr[1:0], and datab = wdata replicated into the addressed lanes.
REQ-019 Error access: ack SHALL still assert, but renb, wenb and webb SHALL be 0.
REQ-020 Response latency SHALL be exactly 1 cycle after acceptance: req_resp[i]=RDY or ERR for one cycle, to the accepted requester only.
REQ-021 Read rdata SHALL be valid with RDY as (qb >> 8*offset), zero-extended by size; rdata SHALL be 0 otherwise.
REQ-022 A pending response register SHALL hold valid, id, offset, width and error; back-to-back acceptance SHALL be allowed every cycle (throughput 1/cycle).
REQ-023 Write-then-read to the same address in consecutive cycles SHALL return the new data (memory write precedes the next-cycle read).
REQ-024 With no request accepted, renb, wenb and webb SHALL be 0 and req_resp SHALL be IDLE the next cycle.

Reset
REQ-025 Reset SHALL clear req_ack=0, req_resp=IDLE, req_rdata=0, renb=wenb=0, webb=0, the pending register and the last-served pointer (=1, so requester 0 wins first).
REQ-026 Reset asserted mid-access SHALL drop the pending response; no RDY/ERR after deassertion.

Structure
REQ-027 SHALL place the cmd, width and resp enums and the byte-mask function in package scr1_tcm_arb_pkg.
REQ-028 SHALL use one sub-module, scr1_tcm_arb_rr, as a 2-way round-robin picker (req[1:0], pointer -> grant one-hot).

Verification
REQ-029 Both requesters reset, then req=2'b11 reads continuously -> acks alternate 0,1,0,1; each RDY arrives 1 cycle after its ack.
REQ-030 Req0 byte write 0xA5 to addr 0x0003 -> webb=4'b1000, datab[31:24]=0xA5; next-cycle read -> rdata=0x000000A5.
REQ-031 Req1 word read at addr 0x0002 -> ack=1, renb=0; next cycle resp[1]=ERR, rdata=0.
REQ-032 Half write 0xBEEF at 0x0010, then word read of 0x0010 on the next cycle -> rdata[15:0]=0xBEEF, upper bytes unchanged.
REQ-033 rst_n low in the cycle after acceptance -> resp IDLE and all memory strobes 0; first request after release is granted to requester 0.
